// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// Data wins by default; a saturating streak counter forces a fetch grant to prevent starvation.
//
// state | meaning
// IDLE  | no transfer; arbitrate eligible requests
// INSTR | fetch transfer outstanding on memory port
// DATA  | load/store transfer outstanding on memory port
module mem_port_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ins_req_i,
  input  logic [29:0] ins_addr_i,
  input  logic        ins_kill_i,
  output logic [31:0] ins_data_o,
  output logic        ins_busywait_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_wstrb_i,
  input  logic [29:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_busywait_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [29:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INSTR = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       ins_done_q, data_done_q;
  logic       kill_seen_q;
  logic [3:0] streak_q;
  logic       eligible_ins, eligible_data;
  logic       grant_ins, grant_data;

  // The done flag masks the stale request of the requester just served.
  assign eligible_ins  = ins_req_i & ~ins_kill_i & ~ins_done_q;
  assign eligible_data = data_req_i & ~data_done_q;

  assign mem_req_o       = (state_q != S_IDLE);
  assign ins_busywait_o  = ins_req_i & ~ins_done_q;
  assign data_busywait_o = data_req_i & ~data_done_q;

  always_comb begin
    state_d    = state_q;
    grant_ins  = 1'b0;
    grant_data = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (eligible_ins && eligible_data && (streak_q == STREAK_MAX)) begin
          grant_ins = 1'b1;
          state_d   = S_INSTR;
        end else if (eligible_data) begin
          grant_data = 1'b1;
          state_d    = S_DATA;
        end else if (eligible_ins) begin
          grant_ins = 1'b1;
          state_d   = S_INSTR;
        end
      end
      S_INSTR: if (mem_ready_i) state_d = S_IDLE;
      S_DATA:  if (mem_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      ins_done_q   <= 1'b0;
      data_done_q  <= 1'b0;
      kill_seen_q  <= 1'b0;
      streak_q     <= 4'd0;
      mem_we_o     <= 1'b0;
      mem_wstrb_o  <= 4'd0;
      mem_addr_o   <= 30'd0;
      mem_wdata_o  <= 32'd0;
      ins_data_o   <= 32'd0;
      data_rdata_o <= 32'd0;
    end else begin
      state_q     <= state_d;
      ins_done_q  <= 1'b0;
      data_done_q <= 1'b0;

      if (grant_ins) begin
        mem_addr_o  <= ins_addr_i;
        mem_we_o    <= 1'b0;
        mem_wstrb_o <= 4'd0;
        mem_wdata_o <= 32'd0;
        streak_q    <= 4'd0;
      end else if (grant_data) begin
        mem_addr_o  <= data_addr_i;
        mem_we_o    <= data_we_i;
        mem_wstrb_o <= data_we_i ? data_wstrb_i : 4'd0;
        mem_wdata_o <= data_wdata_i;
        if (!ins_req_i)
          streak_q <= 4'd0;
        else if (streak_q != STREAK_MAX)
          streak_q <= streak_q + 4'd1;
      end

      // A kill in the completing cycle also counts as seen during the transfer.
      if (state_q == S_INSTR && mem_ready_i) begin
        ins_data_o <= mem_rdata_i;
        ins_done_q <= ~(kill_seen_q | ins_kill_i);
      end
      kill_seen_q <= (state_q == S_INSTR) && !mem_ready_i && (kill_seen_q || ins_kill_i);

      if (state_q == S_DATA && mem_ready_i) begin
        if (!mem_we_o) data_rdata_o <= mem_rdata_i;
        data_done_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized plus directed bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int MAX = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        ins_req_i = 1'b0;
  logic [29:0] ins_addr_i = '0;
  logic        ins_kill_i = 1'b0;
  logic [31:0] ins_data_o;
  logic        ins_busywait_o;
  logic        data_req_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_wstrb_i = '0;
  logic [29:0] data_addr_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic [31:0] data_rdata_o;
  logic        data_busywait_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_wstrb_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ready_i = 1'b0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.MAX_DATA_STREAK(MAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ins_req_i(ins_req_i), .ins_addr_i(ins_addr_i), .ins_kill_i(ins_kill_i),
    .ins_data_o(ins_data_o), .ins_busywait_o(ins_busywait_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_wstrb_i(data_wstrb_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rdata_o(data_rdata_o), .data_busywait_o(data_busywait_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the memory port (0 none, 1 fetch, 2 load/store) and what was granted.
  int          m_owner;
  logic        m_ins_done, m_data_done, m_kill;
  logic [29:0] m_addr;
  logic        m_we;
  logic [3:0]  m_wstrb;
  logic [31:0] m_wdata, m_ins_data, m_rdata;
  int          m_streak, m_wait;

  int          cur_delay = 0;
  int          fixed_delay = -1;
  int          idle_ready_mode = 0;
  bit          rdata_rand = 1'b1;
  logic [31:0] rdata_val = '0;
  bit          kill_hold = 1'b0;
  int          busy_cnt = 0;

  task automatic model_reset();
    m_owner = 0; m_ins_done = 0; m_data_done = 0; m_kill = 0;
    m_addr = '0; m_we = 0; m_wstrb = '0; m_wdata = '0;
    m_ins_data = '0; m_rdata = '0; m_streak = 0; m_wait = 0;
  endtask

  task automatic start_xfer();
    m_wait = 0;
    cur_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
  endtask

  task automatic model_step();
    logic el_i, el_d, n_id, n_dd;
    n_id = 1'b0;
    n_dd = 1'b0;
    if (m_owner == 0) begin
      el_i = ins_req_i && !ins_kill_i && !m_ins_done;
      el_d = data_req_i && !m_data_done;
      if (el_i && (!el_d || m_streak == MAX)) begin
        m_owner = 1; m_addr = ins_addr_i; m_we = 0; m_wstrb = '0;
        m_streak = 0; m_kill = 0;
        start_xfer();
      end else if (el_d) begin
        m_owner = 2; m_addr = data_addr_i; m_we = data_we_i;
        m_wstrb = data_we_i ? data_wstrb_i : 4'd0;
        m_wdata = data_wdata_i;
        m_streak = ins_req_i ? ((m_streak < MAX) ? m_streak + 1 : MAX) : 0;
        start_xfer();
      end
    end else begin
      if (m_owner == 1 && ins_kill_i) m_kill = 1;
      if (mem_ready_i) begin
        if (m_owner == 1) begin
          m_ins_data = mem_rdata_i;
          n_id = !m_kill;
        end else begin
          if (!m_we) m_rdata = mem_rdata_i;
          n_dd = 1'b1;
        end
        m_owner = 0;
      end else begin
        m_wait++;
      end
    end
    m_ins_done  = n_id;
    m_data_done = n_dd;
  endtask

  task automatic check_outputs();
    check_eq("mem_req", mem_req_o, m_owner != 0);
    if (m_owner != 0) begin
      check_eq("mem_addr", mem_addr_o, m_addr);
      check_eq("mem_we", mem_we_o, m_we);
      check_eq("mem_wstrb", mem_wstrb_o, m_wstrb);
      if (m_owner == 2 && m_we) check_eq("mem_wdata", mem_wdata_o, m_wdata);
    end
    check_eq("ins_busywait", ins_busywait_o, ins_req_i & ~m_ins_done);
    check_eq("data_busywait", data_busywait_o, data_req_i & ~m_data_done);
    check_eq("ins_data", ins_data_o, m_ins_data);
    check_eq("data_rdata", data_rdata_o, m_rdata);
    if (ins_busywait_o) busy_cnt++;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    if (m_owner != 0)
      mem_ready_i = (m_wait >= cur_delay);
    else
      mem_ready_i = (idle_ready_mode == 2) ? 1'b1 :
                    (idle_ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_rdata_i = rdata_rand ? $urandom : rdata_val;
    #1;
    check_outputs();
    model_step();
    @(negedge clk_i);
  endtask

  task automatic drive_random();
    if (!ins_req_i || m_ins_done) begin
      ins_req_i  = ($urandom_range(0, 3) != 0);
      ins_addr_i = 30'($urandom);
    end
    if ($urandom_range(0, 19) == 0) kill_hold = ~kill_hold;
    ins_kill_i = kill_hold || ($urandom_range(0, 9) == 0);
    if (ins_kill_i && ins_req_i) ins_addr_i = 30'($urandom);
    if (!data_req_i || m_data_done) begin
      data_req_i   = ($urandom_range(0, 2) != 0);
      data_we_i    = 1'($urandom_range(0, 1));
      data_wstrb_i = 4'($urandom);
      data_addr_i  = 30'($urandom);
      data_wdata_i = $urandom;
    end
  endtask

  task automatic random_phase(input int cycles);
    fixed_delay = -1;
    idle_ready_mode = 1;
    rdata_rand = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      drive_random();
      tick();
    end
  endtask

  // Lets any outstanding transfer finish, then idles both requesters.
  task automatic drain();
    kill_hold = 1'b0;
    ins_kill_i = 1'b0;
    for (int i = 0; i < 30 && m_owner != 0; i++) begin
      tick();
      if (m_data_done) data_req_i = 1'b0;
      if (m_ins_done) ins_req_i = 1'b0;
    end
    ins_req_i = 1'b0;
    data_req_i = 1'b0;
    idle_ready_mode = 0;
    tick();
    tick();
  endtask

  task automatic run_and_release(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (m_data_done) data_req_i = 1'b0;
      if (m_ins_done) ins_req_i = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    tick();

    random_phase(400);
    drain();

    // Reset in the middle of a data write.
    fixed_delay = 6;
    data_req_i = 1'b1; data_we_i = 1'b1; data_wstrb_i = 4'b1010;
    data_addr_i = 30'h155; data_wdata_i = 32'h1234_5678;
    tick(); tick(); tick();
    #2 rst_i = 1'b0;
    #1;
    check_eq("rst_mem_req", mem_req_o, 1'b0);
    check_eq("rst_mem_we", mem_we_o, 1'b0);
    check_eq("rst_mem_wstrb", mem_wstrb_o, 4'd0);
    check_eq("rst_mem_addr", mem_addr_o, 30'd0);
    check_eq("rst_mem_wdata", mem_wdata_o, 32'd0);
    check_eq("rst_data_rdata", data_rdata_o, 32'd0);
    check_eq("rst_ins_data", ins_data_o, 32'd0);
    check_eq("rst_data_busywait", data_busywait_o, data_req_i);
    check_eq("rst_ins_busywait", ins_busywait_o, ins_req_i);
    model_reset();
    mem_ready_i = 1'b0;
    data_req_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    idle_ready_mode = 2;
    tick();
    tick();
    idle_ready_mode = 0;

    // Single fetch, ready one cycle after the request reaches memory.
    fixed_delay = 1;
    rdata_rand = 1'b0;
    rdata_val = 32'hDEAD_BEEF;
    busy_cnt = 0;
    ins_req_i = 1'b1; ins_addr_i = 30'h10;
    run_and_release(8);
    check_eq("fetch_busy_cycles", busy_cnt, 3);
    check_eq("fetch_word", ins_data_o, 32'hDEAD_BEEF);
    rdata_rand = 1'b1;

    // Simultaneous fetch and load.
    fixed_delay = 0;
    ins_req_i = 1'b1; ins_addr_i = 30'h44;
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 30'h99;
    run_and_release(10);

    // Fetch held but killed while loads stream, then released to test the streak limit.
    ins_req_i = 1'b1; ins_addr_i = 30'h55; ins_kill_i = 1'b1;
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 30'h100;
    for (int i = 0; i < 30; i++) begin
      if (i == 18) ins_kill_i = 1'b0;
      tick();
      if (m_data_done) data_addr_i = data_addr_i + 30'd1;
      if (m_ins_done) ins_addr_i = ins_addr_i + 30'd1;
    end
    drain();

    // Kill during an instruction transfer, then redirect to 0x20.
    fixed_delay = 3;
    busy_cnt = 0;
    ins_req_i = 1'b1; ins_addr_i = 30'h30;
    begin
      int n_ticks;
      n_ticks = 0;
      tick(); tick();
      ins_kill_i = 1'b1;
      tick();
      ins_kill_i = 1'b0;
      ins_addr_i = 30'h20;
      n_ticks = 3;
      for (int i = 0; i < 8 && m_owner == 1; i++) begin
        tick();
        n_ticks++;
      end
      fixed_delay = 1;
      tick();
      n_ticks++;
      check_eq("kill_busy_held", busy_cnt, n_ticks);
    end
    run_and_release(8);
    check_eq("redirect_done", ins_busywait_o, 1'b0);

    // Single-byte store leaves the load data register alone.
    fixed_delay = 1;
    data_req_i = 1'b1; data_we_i = 1'b1; data_wstrb_i = 4'b0100;
    data_addr_i = 30'h12; data_wdata_i = 32'h00AB_0000;
    run_and_release(6);

    random_phase(500);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
